uart_tx_fifo: RTL

Transmit-side byte buffer and launcher that sits directly upstream of `uart_transmitter`. Producers push bytes with a single-cycle write strobe. The block queues them in a small circular FIFO and hands them one at a time to the transmitter. For each byte it drives `data_in`, issues a one-cycle `tx_start` pulse, and waits for `tx_done` before launching the next byte. It replaces the constant-data, button-driven start in the UART flag test and will front any later multi-byte frame sender.

---
 rtl/uart_tx_fifo.sv | 91 +++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// Transmit byte queue feeding uart_transmitter.
// Pops one byte per frame and holds it until tx_done.
module uart_tx_fifo #(
  parameter int DBITS     = 8,
  parameter int ADDR_BITS = 2
) (
  input  logic                 clk_100MHz,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [DBITS-1:0]     wr_data,
  input  logic                 tx_done,
  output logic                 tx_start,
  output logic [DBITS-1:0]     tx_data,
  output logic                 full,
  output logic                 empty,
  output logic [ADDR_BITS:0]   count,
  output logic                 busy,
  output logic                 overflow
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } state_t;

  state_t               state;
  logic [DBITS-1:0]     mem [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr;
  logic [ADDR_BITS-1:0] rd_ptr;
  logic                 wr_ok;
  logic                 pop;

  assign full     = (count == (ADDR_BITS+1)'(DEPTH));
  assign empty    = (count == '0);
  assign busy     = (state != IDLE);
  assign tx_start = (state == LAUNCH);

  // full is judged pre-edge, so a write racing a pop from full is dropped
  assign wr_ok = wr_en && !full;
  assign pop   = (state == IDLE) && !empty;

  // storage survives reset; only pointers and count are cleared
  always_ff @(posedge clk_100MHz) begin
    if (wr_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      tx_data  <= '0;
      state    <= IDLE;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + ADDR_BITS'(1);
      end
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
      unique case ({wr_ok, pop})
        2'b10:   count <= count + (ADDR_BITS+1)'(1);
        2'b01:   count <= count - (ADDR_BITS+1)'(1);
        default: count <= count;
      endcase
      unique case (state)
        IDLE: begin
          if (pop) begin
            tx_data <= mem[rd_ptr];
            rd_ptr  <= rd_ptr + ADDR_BITS'(1);
            state   <= LAUNCH;
          end
        end
        LAUNCH: state <= WAIT;
        WAIT: begin
          if (tx_done) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
